// File: rtl/l2_i_refill_responder.sv
// l2_i_refill_responder: 2-way, 16-set read-only L2 that answers L1 instruction line refills and fetches misses from memory.
// Optional hit/miss counters are enabled by defining L2I_PERF_CNT_EN.
module l2_i_refill_responder #(
  parameter int TAG_W  = 22,
  parameter int IDX_W  = 4,
  parameter int LINE_W = 512
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   read_L1_L2,
  input  logic [TAG_W-1:0]       tag_L1_L2,
  input  logic [IDX_W-1:0]       index_L1_L2,
  output logic                   ready_L2_L1,
  output logic [LINE_W-1:0]      read_data_L2_L1,
  input  logic                   flush,
  output logic                   read_L2_MEM,
  output logic [TAG_W+IDX_W-1:0] addr_L2_MEM,
  input  logic                   ready_MEM_L2,
  input  logic [LINE_W-1:0]      read_data_MEM_L2,
`ifdef L2I_PERF_CNT_EN
  output logic [15:0]            hit_cnt_o,
  output logic [15:0]            miss_cnt_o,
`endif
  output logic                   L2I_miss_o
);
  localparam int SETS = 1 << IDX_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, REFILL, RESPOND} state_t;
  state_t state, next_state;
  logic [SETS-1:0] valid [2];
  logic [SETS-1:0] lru;
  logic [TAG_W-1:0] tags [2][SETS];
  logic [LINE_W-1:0] data [2][SETS];
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [LINE_W-1:0] resp, fill;
  logic pend_flush, do_flush, hit0, hit1, hit, victim;
  assign hit0 = valid[0][req_idx] && tags[0][req_idx] == req_tag;
  assign hit1 = valid[1][req_idx] && tags[1][req_idx] == req_tag;
  assign hit = hit0 || hit1;
  assign victim = !valid[0][req_idx] ? 1'b0 : !valid[1][req_idx] ? 1'b1 : lru[req_idx];
  // flush has priority over a request arriving in the same idle cycle
  assign do_flush = state == IDLE && (flush || pend_flush);
  assign ready_L2_L1 = state == RESPOND;
  assign read_data_L2_L1 = resp;
  assign read_L2_MEM = state == MEM_REQ;
  assign addr_L2_MEM = read_L2_MEM ? {req_tag, req_idx} : '0;
  assign L2I_miss_o = state == LOOKUP && !hit;
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = !do_flush && read_L1_L2 ? LOOKUP : IDLE;
      LOOKUP:  next_state = hit ? RESPOND : MEM_REQ;
      MEM_REQ: next_state = ready_MEM_L2 ? REFILL : MEM_REQ;
      REFILL:  next_state = RESPOND;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= next_state;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      valid[0] <= '0;
      valid[1] <= '0;
      lru <= '0;
      pend_flush <= 1'b0;
      req_tag <= '0;
      req_idx <= '0;
      resp <= '0;
`ifdef L2I_PERF_CNT_EN
      hit_cnt_o <= '0;
      miss_cnt_o <= '0;
`endif
    end else begin
      pend_flush <= state == IDLE ? 1'b0 : pend_flush || flush;
      if (do_flush) begin
        valid[0] <= '0;
        valid[1] <= '0;
      end
      if (state == IDLE && !do_flush && read_L1_L2) begin
        req_tag <= tag_L1_L2;
        req_idx <= index_L1_L2;
      end
      if (state == LOOKUP && hit) begin
        resp <= hit0 ? data[0][req_idx] : data[1][req_idx];
        lru[req_idx] <= hit0;
      end
      if (state == REFILL) begin
        valid[victim][req_idx] <= 1'b1;
        lru[req_idx] <= !victim;
        resp <= fill;
      end
`ifdef L2I_PERF_CNT_EN
      if (state == LOOKUP && hit && hit_cnt_o != 16'hFFFF) hit_cnt_o <= hit_cnt_o + 16'd1;
      if (state == LOOKUP && !hit && miss_cnt_o != 16'hFFFF) miss_cnt_o <= miss_cnt_o + 16'd1;
`endif
    end
  // array contents need no reset: valid bits gate every use
  always_ff @(posedge clk) begin
    if (state == MEM_REQ && ready_MEM_L2) fill <= read_data_MEM_L2;
    if (state == REFILL) begin
      tags[victim][req_idx] <= req_tag;
      data[victim][req_idx] <= fill;
    end
  end
endmodule

// File: doc/l2_i_refill_responder.md
# l2_i_refill_responder

L2-side responder for instruction-cache line refills: accepts a line read request (tag + index) from the L1 instruction cache, looks it up in a 2-way, 16-set, 64-byte-line L2 array (2 KB), and returns the full 512-bit line with a one-cycle ready pulse. L2 misses are fetched from main memory over a request/ready interface, installed in the L2 array, then forwarded to L1. Read-only: no dirty state, no write-back.

## Interface
Parameters:
- TAG_W, 22, tag width (address bits 31:10)
- IDX_W, 4, set index width (address bits 9:6); sets = 2^IDX_W
- LINE_W, 512, line width in bits

Ports:
- clk  input  1  clock, all state updates on rising edge
- nrst  input  1  asynchronous active-low reset
- read_L1_L2  input  1  L1 line request, held high until ready_L2_L1
- tag_L1_L2  input  TAG_W  requested tag, stable while read_L1_L2 high
- index_L1_L2  input  IDX_W  requested set, stable while read_L1_L2 high
- ready_L2_L1  output  1  one-cycle pulse: read_data_L2_L1 valid
- read_data_L2_L1  output  LINE_W  returned line
- flush  input  1  invalidate every L2 line
- read_L2_MEM  output  1  memory line request, held until ready_MEM_L2
- addr_L2_MEM  output  TAG_W+IDX_W  line address {tag, index}
- ready_MEM_L2  input  1  one-cycle pulse: read_data_MEM_L2 valid
- read_data_MEM_L2  input  LINE_W  memory line
- L2I_miss_o  output  1  high for one cycle when a lookup misses

## Operation
- State: per set, per way: valid bit, TAG_W tag, LINE_W data; per set one LRU bit (way to evict next).
- FSM states: IDLE, LOOKUP, MEM_REQ, REFILL, RESPOND.
- IDLE: read_L1_L2=1 -> latch tag/index into request registers, go LOOKUP.
- LOOKUP: hit = valid & tag match in either way. Hit -> latch way data into response register, LRU := other way, go RESPOND. Miss -> L2I_miss_o=1, go MEM_REQ.
- MEM_REQ: read_L2_MEM=1, addr_L2_MEM={latched tag, index}; on ready_MEM_L2=1 go REFILL, capture read_data_MEM_L2.
- REFILL: victim = way0 if invalid, else way1 if invalid, else LRU way. Write data, tag, valid=1; LRU := other way; response register := fill data; go RESPOND.
- RESPOND: ready_L2_L1=1, read_data_L2_L1 = response register; go IDLE.
- read_data_L2_L1 holds last response value outside RESPOND; only valid while ready_L2_L1=1.
- flush: in IDLE, clears all valid bits (LRU unchanged) that cycle, request sampling still proceeds using pre-flush state is not allowed: flush has priority, request waits one cycle. Flush outside IDLE is latched and applied on the next IDLE cycle, before any new request.
- Request still high in IDLE after RESPOND is treated as a new request (L1 must drop it the cycle after ready).
- ready_MEM_L2 outside MEM_REQ ignored.

## Timing
- Reset (async assert, any state): state IDLE, all valid=0, LRU=0, pending flush=0; ready_L2_L1=0, read_data_L2_L1=0, read_L2_MEM=0, addr_L2_MEM=0, L2I_miss_o=0. Reset mid-miss abandons the memory request; later ready_MEM_L2 ignored.
- Hit: request sampled at edge N -> ready_L2_L1 high in cycle N+2 (LOOKUP at N+1).
- Miss: read_L2_MEM rises cycle N+2; ready_MEM_L2 at cycle M -> REFILL M+1, ready_L2_L1 at M+2. Array write in REFILL visible to lookups from M+2 on.
- One outstanding request; no pipelining.

## Configuration
- L2I_PERF_CNT_EN defined: adds outputs hit_cnt_o[15:0] and miss_cnt_o[15:0], incremented in LOOKUP on hit/miss, saturating at 16'hFFFF, reset to 0, unaffected by flush.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Cold miss: reset, request tag=0x12345, index=3; memory replies 10 cycles later with line 0xA5 pattern -> L2I_miss_o pulse, read_L2_MEM addr=0x123453, ready_L2_L1 two cycles after ready_MEM_L2 with 0xA5 pattern.
- Hit: repeat same request -> ready_L2_L1 exactly 2 cycles after sampling, same data, no read_L2_MEM.
- Replacement: index 5 tags 0x1, 0x2, hit 0x1, then 0x3 -> 0x3 evicts way holding 0x2; next 0x1 hits, next 0x2 misses.
- Flush: fill index 0 tag 0x7, pulse flush in IDLE, request 0x7 -> miss and memory request.
- Reset mid-miss: assert nrst=0 while in MEM_REQ, release, deliver stale ready_MEM_L2 -> no ready_L2_L1, all outputs 0, next request misses.
- With L2I_PERF_CNT_EN: 3 misses then 2 hits -> miss_cnt_o=3, hit_cnt_o=2.
